// File: rtl/uart_wb_master.sv
// UART-to-Wishbone debug bridge: 8N1 'W'/'R' command frames become single
// Wishbone classic cycles, answered with 'K' (+ read data) or 'E' on timeout.
module uart_wb_master #(
    parameter logic [15:0] CLKDIV  = 16'd16,
    parameter int unsigned AW      = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_i,
    output logic          tx_o,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [31:0]   dat_o,
    input  logic [31:0]   dat_i,
    input  logic          ack_i,
    output logic          busy_o
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic        rx_act_q;
    logic [15:0] rx_cnt_q;
    logic [3:0]  rx_bit_q;
    logic [7:0]  rx_sh_q;
    logic        rx_vld_q, rx_ferr_q;

    state_t          state_q;
    logic [1:0]      nbyte_q;
    logic            wr_q;
    logic [31:0]     addr_q;
    logic [23:0]     data_q;
    logic [31:0]     to_cnt_q;
    logic [39:0]     resp_q;
    logic [8:0]      tx_sh_q;
    logic [15:0]     tx_cnt_q;
    logic [3:0]      tx_bits_q;
    logic [2:0]      tx_bytes_q;
    logic            tx_q, cyc_q, stb_q, we_q, busy_q;
    logic [AW-1:0]   adr_q;
    logic [31:0]     dat_q;

    logic [31:0]     addr_d;
    logic [31:0]     data_d;
    logic            to_hit_d;

    assign addr_d   = {addr_q[23:0], rx_sh_q};
    assign data_d   = {data_q, rx_sh_q};
    assign to_hit_d = (TIMEOUT != 32'd0) && ((to_cnt_q + 32'd1) == TIMEOUT);

    // Receiver: synchronize, detect start edge, sample mid-bit, flag good/bad stop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_act_q  <= 1'b0;
            rx_cnt_q  <= 16'd0;
            rx_bit_q  <= 4'd0;
            rx_sh_q   <= 8'd0;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            if (!rx_act_q) begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_act_q <= 1'b1;
                    rx_cnt_q <= (CLKDIV >> 1) - 16'd1;
                    rx_bit_q <= 4'd0;
                end
            end else if (rx_cnt_q != 16'd0) begin
                rx_cnt_q <= rx_cnt_q - 16'd1;
            end else begin
                rx_cnt_q <= CLKDIV - 16'd1;
                rx_bit_q <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_s2_q) begin
                        rx_act_q <= 1'b0;
                    end
                end else if (rx_bit_q == 4'd9) begin
                    rx_act_q  <= 1'b0;
                    rx_vld_q  <= rx_s2_q;
                    rx_ferr_q <= !rx_s2_q;
                end else begin
                    rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
                end
            end
        end
    end

    // Command parser, bus sequencer and response transmitter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            nbyte_q    <= 2'd0;
            wr_q       <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 24'd0;
            to_cnt_q   <= 32'd0;
            resp_q     <= 40'd0;
            tx_sh_q    <= 9'h1FF;
            tx_cnt_q   <= 16'd0;
            tx_bits_q  <= 4'd0;
            tx_bytes_q <= 3'd0;
            tx_q       <= 1'b1;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_vld_q && (rx_sh_q == 8'h57 || rx_sh_q == 8'h52)) begin
                        wr_q    <= (rx_sh_q == 8'h57);
                        nbyte_q <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_ferr_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (rx_vld_q) begin
                        addr_q  <= addr_d;
                        nbyte_q <= nbyte_q + 2'd1;
                        if (nbyte_q == 2'd3) begin
                            if (wr_q) begin
                                state_q <= S_DATA;
                            end else begin
                                state_q  <= S_BUS;
                                cyc_q    <= 1'b1;
                                stb_q    <= 1'b1;
                                we_q     <= 1'b0;
                                adr_q    <= AW'(addr_d);
                                to_cnt_q <= 32'd0;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (rx_ferr_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (rx_vld_q) begin
                        data_q  <= data_d[23:0];
                        nbyte_q <= nbyte_q + 2'd1;
                        if (nbyte_q == 2'd3) begin
                            state_q  <= S_BUS;
                            cyc_q    <= 1'b1;
                            stb_q    <= 1'b1;
                            we_q     <= 1'b1;
                            adr_q    <= AW'(addr_q);
                            dat_q    <= data_d;
                            to_cnt_q <= 32'd0;
                        end
                    end
                end
                S_BUS: begin
                    // ack wins over a timeout landing on the same edge
                    if (ack_i || to_hit_d) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        state_q    <= S_RESP;
                        tx_cnt_q   <= 16'd0;
                        tx_bits_q  <= 4'd0;
                        resp_q     <= ack_i ? {8'h4B, dat_i} : {8'h45, 32'd0};
                        tx_bytes_q <= (ack_i && !wr_q) ? 3'd5 : 3'd1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
                end
                S_RESP: begin
                    if (tx_cnt_q != 16'd0) begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end else if (tx_bits_q != 4'd0) begin
                        tx_q      <= tx_sh_q[0];
                        tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
                        tx_bits_q <= tx_bits_q - 4'd1;
                        tx_cnt_q  <= CLKDIV - 16'd1;
                    end else if (tx_bytes_q != 3'd0) begin
                        tx_q       <= 1'b0;
                        tx_sh_q    <= {1'b1, resp_q[39:32]};
                        resp_q     <= {resp_q[31:0], 8'h00};
                        tx_bytes_q <= tx_bytes_q - 3'd1;
                        tx_bits_q  <= 4'd9;
                        tx_cnt_q   <= CLKDIV - 16'd1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = stb_q;
    assign we_o   = we_q;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;
    assign busy_o = busy_q;

endmodule
